// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller: FSM states,
// forwarding selects and the load result-source encoding.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle; the controller uses the slave
// modport, the pipeline (or bench) the master modport.
interface hazard_ctrl_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int READ_DATA_WIDTH = 5
) ();

    logic [READ_DATA_WIDTH-1:0] Rs1_d, Rs2_d;
    logic [READ_DATA_WIDTH-1:0] Rs1_e, Rs2_e, Rd_e;
    logic [READ_DATA_WIDTH-1:0] Rd_m, Rd_w;
    logic                       RegWrite_e, RegWrite_m, RegWrite_w;
    logic [1:0]                 ResultSrc_e;
    logic                       PCSrc_e;
    logic                       icache_busy_f;
    logic                       dcache_busy_m;

    logic                       icache_abort;
    logic                       en_f, en_d, en_e, en_m, en_w;
    logic                       flush_n_d, flush_n_e, flush_n_m, flush_n_w;
    logic [1:0]                 ForwardA_e, ForwardB_e;
    logic [DATA_WIDTH-1:0]      stall_cycles;

    modport master (
        output Rs1_d, Rs2_d, Rs1_e, Rs2_e, Rd_e, Rd_m, Rd_w,
               RegWrite_e, RegWrite_m, RegWrite_w, ResultSrc_e,
               PCSrc_e, icache_busy_f, dcache_busy_m,
        input  icache_abort, en_f, en_d, en_e, en_m, en_w,
               flush_n_d, flush_n_e, flush_n_m, flush_n_w,
               ForwardA_e, ForwardB_e, stall_cycles
    );

    modport slave (
        input  Rs1_d, Rs2_d, Rs1_e, Rs2_e, Rd_e, Rd_m, Rd_w,
               RegWrite_e, RegWrite_m, RegWrite_w, ResultSrc_e,
               PCSrc_e, icache_busy_f, dcache_busy_m,
        output icache_abort, en_f, en_d, en_e, en_m, en_w,
               flush_n_d, flush_n_e, flush_n_m, flush_n_w,
               ForwardA_e, ForwardB_e, stall_cycles
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Forwarding-select and RAW-stall detection. HAZARD_FORWARDING_EN selects
// bypassing (load-use only stalls) versus full E/M RAW interlock with no bypass.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int READ_DATA_WIDTH = 5
) (
    input  logic [READ_DATA_WIDTH-1:0] Rs1_d,
    input  logic [READ_DATA_WIDTH-1:0] Rs2_d,
    input  logic [READ_DATA_WIDTH-1:0] Rs1_e,
    input  logic [READ_DATA_WIDTH-1:0] Rs2_e,
    input  logic [READ_DATA_WIDTH-1:0] Rd_e,
    input  logic [READ_DATA_WIDTH-1:0] Rd_m,
    input  logic [READ_DATA_WIDTH-1:0] Rd_w,
    input  logic                       RegWrite_e,
    input  logic                       RegWrite_m,
    input  logic                       RegWrite_w,
    input  logic [1:0]                 ResultSrc_e,
    output fwd_sel_t                   fwd_a,
    output fwd_sel_t                   fwd_b,
    output logic                       stall_raw
);

    logic e_hits_d;
    logic m_hits_d;

    assign e_hits_d = RegWrite_e && (Rd_e != '0) && ((Rd_e == Rs1_d) || (Rd_e == Rs2_d));
    assign m_hits_d = RegWrite_m && (Rd_m != '0) && ((Rd_m == Rs1_d) || (Rd_m == Rs2_d));

`ifdef HAZARD_FORWARDING_EN
    function automatic fwd_sel_t pick(input logic [READ_DATA_WIDTH-1:0] rs);
        if (RegWrite_m && (Rd_m != '0) && (Rd_m == rs))
            return FWD_M;
        else if (RegWrite_w && (Rd_w != '0) && (Rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    logic unused_m_hit;

    assign fwd_a        = pick(Rs1_e);
    assign fwd_b        = pick(Rs2_e);
    assign stall_raw    = e_hits_d && (ResultSrc_e == RESULT_SRC_LOAD);
    assign unused_m_hit = m_hits_d;
`else
    logic unused_fwd_inputs;

    assign fwd_a     = FWD_RF;
    assign fwd_b     = FWD_RF;
    // W is not checked: the regfile writes through to same-cycle reads.
    assign stall_raw = e_hits_d || m_hits_d;
    assign unused_fwd_inputs = ^{Rs1_e, Rs2_e, Rd_w, RegWrite_w, ResultSrc_e};
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stalls, flushes, cache-miss FSM, forwarding
// selects and a saturating stall counter. Optional macro: HAZARD_FORWARDING_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int READ_DATA_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    hazard_state_t         state, state_next;
    fwd_sel_t              fwd_a, fwd_b;
    logic                  stall_raw;
    logic [DATA_WIDTH-1:0] stall_q;

    hazard_fwd_unit #(.READ_DATA_WIDTH(READ_DATA_WIDTH)) u_fwd (
        .Rs1_d       (hz.Rs1_d),
        .Rs2_d       (hz.Rs2_d),
        .Rs1_e       (hz.Rs1_e),
        .Rs2_e       (hz.Rs2_e),
        .Rd_e        (hz.Rd_e),
        .Rd_m        (hz.Rd_m),
        .Rd_w        (hz.Rd_w),
        .RegWrite_e  (hz.RegWrite_e),
        .RegWrite_m  (hz.RegWrite_m),
        .RegWrite_w  (hz.RegWrite_w),
        .ResultSrc_e (hz.ResultSrc_e),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_raw   (stall_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next      = state;
        hz.en_f         = 1'b1;
        hz.en_d         = 1'b1;
        hz.en_e         = 1'b1;
        hz.en_m         = 1'b1;
        hz.en_w         = 1'b1;
        hz.flush_n_d    = 1'b1;
        hz.flush_n_e    = 1'b1;
        hz.flush_n_m    = 1'b1;
        hz.flush_n_w    = 1'b1;
        hz.icache_abort = 1'b0;
        hz.ForwardA_e   = fwd_a;
        hz.ForwardB_e   = fwd_b;

        if (rst) begin
            hz.flush_n_d  = 1'b0;
            hz.flush_n_e  = 1'b0;
            hz.flush_n_m  = 1'b0;
            hz.flush_n_w  = 1'b0;
            hz.ForwardA_e = FWD_RF;
            hz.ForwardB_e = FWD_RF;
            state_next    = RUN;
        end else if (hz.dcache_busy_m) begin
            hz.en_f      = 1'b0;
            hz.en_d      = 1'b0;
            hz.en_e      = 1'b0;
            hz.en_m      = 1'b0;
            hz.flush_n_w = 1'b0;
            state_next   = D_WAIT;
        end else if (state == D_WAIT) begin
            // Resume cycle: everything advances; a branch frozen in E still redirects.
            state_next = RUN;
            if (hz.PCSrc_e) begin
                hz.flush_n_d = 1'b0;
                hz.flush_n_e = 1'b0;
            end
        end else if (hz.PCSrc_e) begin
            hz.flush_n_d    = 1'b0;
            hz.flush_n_e    = 1'b0;
            hz.icache_abort = (state == I_WAIT);
            state_next      = RUN;
        end else if (stall_raw) begin
            hz.en_f      = 1'b0;
            hz.en_d      = 1'b0;
            hz.flush_n_e = 1'b0;
            state_next   = hz.icache_busy_f ? I_WAIT : RUN;
        end else if (hz.icache_busy_f) begin
            hz.en_f      = 1'b0;
            hz.flush_n_d = 1'b0;
            state_next   = I_WAIT;
        end else begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (!hz.en_f && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
    end

    assign hz.stall_cycles = stall_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the pipelined-plus-cache RV32I core. It drives the stall enable (`en_*`, active-high enable) and flush (`flush_n_*`, active-low) inputs of the F/D, D/E, E/M and M/W pipeline registers. It resolves load-use hazards, taken-branch redirects and instruction/data cache miss stalls, and selects forwarding paths. A small FSM tracks cache-miss waits, and a saturating counter reports stall cycles.

## Interface
- `DATA_WIDTH`, 32: width of the stall counter.
- `READ_DATA_WIDTH`, 5: register index width.
- `clk`  in  1  single clock, all state on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `Rs1_d`, `Rs2_d`  in  READ_DATA_WIDTH  D-stage source registers.
- `Rs1_e`, `Rs2_e`, `Rd_e`  in  READ_DATA_WIDTH  E-stage sources and destination.
- `Rd_m`, `Rd_w`  in  READ_DATA_WIDTH  M-stage and W-stage destinations.
- `RegWrite_e`, `RegWrite_m`, `RegWrite_w`  in  1  register-write flags per stage.
- `ResultSrc_e`  in  2  2'b01 marks a load in E.
- `PCSrc_e`  in  1  taken branch or jump resolved in E.
- `icache_busy_f`  in  1  fetch not yet returned (miss in progress).
- `dcache_busy_m`  in  1  M-stage access not yet complete.
- `icache_abort`  out  1  one-cycle pulse that cancels an outstanding fetch miss.
- `en_f`, `en_d`, `en_e`, `en_m`, `en_w`  out  1  register enables (0 = hold).
- `flush_n_d`, `flush_n_e`, `flush_n_m`, `flush_n_w`  out  1  bubble insert (0 = clear).
- `ForwardA_e`, `ForwardB_e`  out  2  00 = regfile, 10 = ALUResult_m, 01 = Result_w.
- `stall_cycles`  out  DATA_WIDTH  saturating count of cycles with `en_f`=0.

## Operation
- FSM states: RUN, I_WAIT, D_WAIT. State is registered. Enable and flush outputs are combinational from the state and current inputs.
- Output priority: rst > dcache_busy_m > PCSrc_e > load-use > icache_busy_f.
- **rst:** all `flush_n_*`=0, all `en_*`=1, forwards 00, `icache_abort`=0. Next state is RUN and `stall_cycles` is 0.
- **dcache_busy_m=1:** `en_f`, `en_d`, `en_e`, `en_m`=0 and `flush_n_w`=0 (W gets a bubble; no double write). Next state is D_WAIT. PCSrc_e and load-use are ignored because E is frozen.
- **D_WAIT with dcache_busy_m=0:** all enables are 1 and the next state is RUN. The M instruction advances on this cycle.
- **PCSrc_e=1:** `flush_n_d`=0 and `flush_n_e`=0, all enables 1, no load-use stall. If the state is I_WAIT, `icache_abort` pulses and the next state is RUN.
- **Load-use:** triggered when `RegWrite_e`, `ResultSrc_e`=01, `Rd_e`≠0 and `Rd_e` matches `Rs1_d` or `Rs2_d`. Then `en_f`=`en_d`=0 and `flush_n_e`=0. This lasts exactly one cycle per occurrence.
- **icache_busy_f=1 (no higher event):** `en_f`=0 and `flush_n_d`=0, so the D register gets a bubble. E/M/W advance. Next state is I_WAIT, which is left when `icache_busy_f`=0.
- **Forwarding:** M is preferred over W. A match requires `Rd`≠0 and the corresponding `RegWrite`. Register x0 is never forwarded.
- **stall_cycles:** increments on every cycle with `en_f`=0 and saturates at all-ones.

## Timing
- Zero-cycle combinational path from `*_busy`, `PCSrc_e` and hazard inputs to the enables and flushes.
- State update and `stall_cycles` update are registered, visible the cycle after.
- Load-use costs 1 cycle. A taken branch costs 2 bubbles. A D-miss costs N cycles of busy, with resume in the first cycle after busy drops.
- Reset mid-miss returns to RUN at once. The cache owns its own recovery.
- Busy asserted in the reset cycle is ignored.
- Simultaneous `dcache_busy_m` and `icache_busy_f`: D_WAIT wins. I_WAIT is re-entered afterwards if the I-miss is still pending.

## Configuration
- `HAZARD_FORWARDING_EN` defined:
  - Forwarding selects are driven as above.
  - Only load-use stalls.
- `HAZARD_FORWARDING_EN` undefined:
  - `ForwardA_e`/`ForwardB_e` are tied to 00.
  - Any RAW hazard of `Rs1_d`/`Rs2_d` against a writing `Rd_e` or `Rd_m` (≠0) stalls F/D and flushes E until clear.
  - The regfile is write-through, so the W stage is not checked.

## Structure
- Package `hazard_pkg` holds:
  - the `hazard_state_t` enum (RUN, I_WAIT, D_WAIT);
  - the `fwd_sel_t` enum (FWD_RF, FWD_W, FWD_M);
  - the `RESULT_SRC_LOAD` constant (2'b01).
- One sub-module, `hazard_fwd_unit`: combinational forwarding and RAW match logic, instantiated once.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `dcache_busy_m`=1 → all `flush_n_*`=0, `stall_cycles`=0, state RUN after release.
- **Load-use:** `lw x5` in E, `add x6,x5,x1` in D → `en_f`=`en_d`=0 and `flush_n_e`=0 for exactly 1 cycle, then `ForwardA_e`=01 when the add is in E.
- **Branch vs load-use:** `PCSrc_e`=1 together with load-use → `flush_n_d`=`flush_n_e`=0, `en_f`=1, no stall.
- **D-miss:** `dcache_busy_m` high for 4 cycles → F/D/E/M held 4 cycles, W bubbles, `stall_cycles`=4, RUN after.
- **I-miss abort:** `icache_busy_f` high for 3 cycles, `PCSrc_e`=1 in cycle 2 → `icache_abort` pulses in cycle 2, state RUN in cycle 3.
- **Without `HAZARD_FORWARDING_EN`:** `add x7` in M, `sub x8,x7,x7` in D → stall 1 cycle; forwards remain 00.
